// File: rtl/input_map_pkg.sv
// Shared constants and types for the arcade input mapper: scan codes,
// joystick bit layout, rotation and coin FSM encodings.
package input_map_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Player 0 keys
  localparam logic [8:0] SC_UP    = 9'h175;
  localparam logic [8:0] SC_DOWN  = 9'h172;
  localparam logic [8:0] SC_LEFT  = 9'h16B;
  localparam logic [8:0] SC_RIGHT = 9'h174;
  localparam logic [8:0] SC_CTRL  = 9'h014;
  localparam logic [8:0] SC_SPACE = 9'h029;
  localparam logic [8:0] SC_ALT   = 9'h011;
  localparam logic [8:0] SC_SHIFT = 9'h012;
  localparam logic [8:0] SC_Z     = 9'h01A;
  localparam logic [8:0] SC_F1    = 9'h005;
  localparam logic [8:0] SC_5     = 9'h02E;

  // Player 1 keys
  localparam logic [8:0] SC_R  = 9'h02D;
  localparam logic [8:0] SC_F  = 9'h02B;
  localparam logic [8:0] SC_D  = 9'h023;
  localparam logic [8:0] SC_G  = 9'h034;
  localparam logic [8:0] SC_A  = 9'h01C;
  localparam logic [8:0] SC_S  = 9'h01B;
  localparam logic [8:0] SC_Q  = 9'h015;
  localparam logic [8:0] SC_W  = 9'h01D;
  localparam logic [8:0] SC_F2 = 9'h006;
  localparam logic [8:0] SC_6  = 9'h036;

  typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_e;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_e;

  localparam int unsigned JS_R = 0;
  localparam int unsigned JS_L = 1;
  localparam int unsigned JS_D = 2;
  localparam int unsigned JS_U = 3;

  function automatic int unsigned js_fire(input int unsigned idx);
    return 32'd4 + idx;
  endfunction

  function automatic int unsigned js_start(input int unsigned buttons);
    return 32'd4 + buttons;
  endfunction

  function automatic int unsigned js_coin(input int unsigned buttons);
    return 32'd5 + buttons;
  endfunction

  // Coin counter is at least 16 bits, wider only when a length needs it.
  function automatic int unsigned cnt_width(input int unsigned pulse, input int unsigned gap);
    int unsigned m;
    m = (pulse > gap) ? pulse : gap;
    return (m < 32'd65536) ? 32'd16 : 32'($clog2(m + 32'd1));
  endfunction

  // Direction vectors are {U,D,L,R}; maps raw directions to screen directions.
  function automatic logic [3:0] rotate_dir(input logic [3:0] d, input rot_e r);
    case (r)
      ROT_90:  return {d[JS_L], d[JS_R], d[JS_D], d[JS_U]};
      ROT_180: return {d[JS_D], d[JS_U], d[JS_R], d[JS_L]};
      ROT_270: return {d[JS_R], d[JS_L], d[JS_U], d[JS_D]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/coin_pulser.sv
// Turns a coin request rising edge into a fixed-width pulse followed by a
// lockout gap; edges arriving during the pulse or gap are dropped.
module coin_pulser
  import input_map_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 50000,
  parameter int unsigned GAP_LEN   = 100000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin
);

  coin_state_e      state;
  logic             req_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      req_d <= 1'b0;
      cnt   <= '0;
      coin  <= 1'b0;
    end else begin
      req_d <= req;
      case (state)
        IDLE: begin
          if (req && !req_d) begin
            state <= PULSE;
            cnt   <= CNT_W'(PULSE_LEN - 32'd1);
            coin  <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            coin <= 1'b0;
            if (GAP_LEN == 32'd0) begin
              state <= IDLE;
            end else begin
              state <= GAP;
              cnt   <= CNT_W'(GAP_LEN);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state <= IDLE;
          coin  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Keyboard + joystick front end: PS/2 key latches, merge, rotation, coin pulses.
// Define INPUT_MAPPER_AUTOFIRE_EN to build the autofire toggle on p_btn[0].
module arcade_input_mapper
  import input_map_pkg::*;
#(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned BUTTONS      = 2,
  parameter int unsigned COIN_PULSE   = 50000,
  parameter int unsigned COIN_GAP     = 100000,
  parameter int unsigned AUTOFIRE_DIV = 300000
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic [64:0]                  ps2_key,
  input  logic [15:0]                  joystick_0,
  input  logic [15:0]                  joystick_1,
  input  logic [1:0]                   rotate,
  input  logic                         coin_on_start,
  input  logic                         autofire,
  output logic [4*PLAYERS-1:0]         p_dir,
  output logic [BUTTONS*PLAYERS-1:0]   p_btn,
  output logic [PLAYERS-1:0]           p_start,
  output logic [PLAYERS-1:0]           p_coin
);

  localparam int unsigned CNT_W    = cnt_width(COIN_PULSE, COIN_GAP);
  localparam int unsigned AF_W     = 20;
  localparam int unsigned IX_START = js_start(BUTTONS);
  localparam int unsigned IX_COIN  = js_coin(BUTTONS);

  logic            old_tgl;
  logic            key_event;
  logic            pressed;
  logic            extended;
  logic [8:0]      code;

  logic [1:0][3:0] kb_dir;
  logic [1:0][3:0] kb_fire;
  logic [1:0]      kb_start;
  logic [1:0]      kb_coin;

  logic [1:0][15:0] js;
  logic [1:0][3:0]  raw_dir;
  logic [1:0][3:0]  raw_fire;
  logic [1:0]       raw_start;
  logic [1:0]       raw_coin;
  logic [1:0]       coin_req;
  logic             fire0_next;

  // Event decode; events with junk in the upper word decode to no key.
  always_comb begin
    key_event = (old_tgl != ps2_key[64]);
    pressed   = (ps2_key[15:8] != PS2_BREAK);
    extended  = (ps2_key[15:8] == PS2_EXT);
    code      = (ps2_key[63:24] == '0) ? {extended, ps2_key[7:0]} : 9'h000;
  end

  // Arrow keys match on the low byte so plain F0 breaks release them too.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_tgl  <= 1'b0;
      kb_dir   <= '0;
      kb_fire  <= '0;
      kb_start <= '0;
      kb_coin  <= '0;
    end else begin
      old_tgl <= ps2_key[64];
      if (key_event) begin
        if (code[7:0] == SC_UP[7:0])    kb_dir[0][JS_U] <= pressed;
        if (code[7:0] == SC_DOWN[7:0])  kb_dir[0][JS_D] <= pressed;
        if (code[7:0] == SC_LEFT[7:0])  kb_dir[0][JS_L] <= pressed;
        if (code[7:0] == SC_RIGHT[7:0]) kb_dir[0][JS_R] <= pressed;
        if (code == SC_CTRL || code == SC_SPACE) kb_fire[0][0] <= pressed;
        if (BUTTONS > 32'd1 && code == SC_ALT)   kb_fire[0][1] <= pressed;
        if (BUTTONS > 32'd2 && code == SC_SHIFT) kb_fire[0][2] <= pressed;
        if (BUTTONS > 32'd3 && code == SC_Z)     kb_fire[0][3] <= pressed;
        if (code == SC_F1) kb_start[0] <= pressed;
        if (code == SC_5)  kb_coin[0]  <= pressed;
        if (PLAYERS > 32'd1) begin
          if (code == SC_R) kb_dir[1][JS_U] <= pressed;
          if (code == SC_F) kb_dir[1][JS_D] <= pressed;
          if (code == SC_D) kb_dir[1][JS_L] <= pressed;
          if (code == SC_G) kb_dir[1][JS_R] <= pressed;
          if (code == SC_A)                    kb_fire[1][0] <= pressed;
          if (BUTTONS > 32'd1 && code == SC_S) kb_fire[1][1] <= pressed;
          if (BUTTONS > 32'd2 && code == SC_Q) kb_fire[1][2] <= pressed;
          if (BUTTONS > 32'd3 && code == SC_W) kb_fire[1][3] <= pressed;
          if (code == SC_F2) kb_start[1] <= pressed;
          if (code == SC_6)  kb_coin[1]  <= pressed;
        end
      end
    end
  end

  // Single-player builds fold both joysticks onto player 0.
  assign js[0] = (PLAYERS == 32'd1) ? (joystick_0 | joystick_1) : joystick_0;
  assign js[1] = joystick_1;

  always_comb begin
    raw_dir   = '0;
    raw_fire  = '0;
    raw_start = '0;
    raw_coin  = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      raw_dir[p] = kb_dir[p] | js[p][3:0];
      for (int unsigned b = 0; b < BUTTONS; b++) begin
        raw_fire[p][b] = kb_fire[p][b] | js[p][js_fire(b)];
      end
      raw_start[p] = kb_start[p] | js[p][IX_START];
      raw_coin[p]  = kb_coin[p]  | js[p][IX_COIN];
    end
  end

`ifdef INPUT_MAPPER_AUTOFIRE_EN
  logic            af_active;
  logic            af_phase;
  logic [AF_W-1:0] af_cnt;

  assign af_active = autofire & raw_fire[0][0];

  // Phase 0 is the high half; the counter restarts whenever fire 0 is released.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (!af_active) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AF_W'(AUTOFIRE_DIV - 32'd1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  assign fire0_next = af_active ? ~af_phase : raw_fire[0][0];
`else
  assign fire0_next = raw_fire[0][0];
`endif

  // Output and coin-request registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p_dir    <= '0;
      p_btn    <= '0;
      p_start  <= '0;
      coin_req <= '0;
    end else begin
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        p_dir[4*p +: 4] <= rotate_dir(raw_dir[p], rot_e'(rotate));
        for (int unsigned b = 0; b < BUTTONS; b++) begin
          p_btn[BUTTONS*p + b] <= raw_fire[p][b];
        end
        p_start[p]  <= raw_start[p];
        coin_req[p] <= raw_coin[p] | (coin_on_start & raw_start[p]);
      end
      p_btn[0] <= fire0_next;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
    coin_pulser #(
      .PULSE_LEN (COIN_PULSE),
      .GAP_LEN   (COIN_GAP),
      .CNT_W     (CNT_W)
    ) u_coin (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .req     (coin_req[p]),
      .coin    (p_coin[p])
    );
  end

  logic unused_bits;
  assign unused_bits = ^{ps2_key[23:16], joystick_0, joystick_1, autofire,
                         raw_dir, raw_fire, coin_req, kb_fire};

endmodule
